neuron_mac_seq: RTL and testbench

Sequential, parametrised neuron. It accumulates a bias plus N_INPUTS signed x·w products, one product per accepted beat, on a single shared multiplier. It then applies a selectable activation and presents a saturated result through a valid/ready output handshake. It is the successor to the 4-input combinational full_neuron and sits between the input/weight streamers and the layer output buffer.

---
 rtl/neuron_mac_seq.sv | 133 +++++++++++++
 tb/tb_neuron_mac_seq.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/neuron_mac_seq.sv
// Sequential neuron: bias plus N_INPUTS signed x*w products accumulated on one
// shared multiplier, then activation, saturation and a valid/ready result port.
module neuron_mac_seq #(
    parameter int DATA_W     = 8,
    parameter int N_INPUTS   = 4,
    parameter int ACC_W      = 18,
    parameter int LEAK_SHIFT = 3
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     start,
    input  logic signed [DATA_W-1:0] bias_in,
    input  logic [1:0]               act_mode,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic signed [DATA_W-1:0] x_in,
    input  logic signed [DATA_W-1:0] w_in,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic signed [ACC_W-1:0]  neuron_output,
    output logic                     sat,
    output logic [1:0]               state_dbg
);

    localparam int CW = $clog2(N_INPUTS);
    localparam int AW = 2 * DATA_W + CW + 1;

    // Handshakes: a beat moves on a clock edge where in_valid && in_ready;
    // a result moves on an edge where out_valid && out_ready.
    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ACCUM = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    state_t                   state;
    state_t                   state_next;
    logic signed [AW-1:0]     acc;
    logic [CW-1:0]            cnt;
    logic [1:0]               mode_r;
    logic signed [2*DATA_W-1:0] prod;
    logic signed [AW-1:0]     sum;
    logic signed [AW-1:0]     act_sum;
    logic signed [ACC_W-1:0]  res;
    logic                     res_sat;
    logic                     beat;
    logic                     last_beat;

    assign prod      = x_in * w_in;
    assign sum       = acc + {{(AW - 2 * DATA_W){prod[2*DATA_W-1]}}, prod};
    assign beat      = in_valid && in_ready;
    assign last_beat = beat && (cnt == CW'(N_INPUTS - 1));
    assign state_dbg = state;

    always_comb begin
        act_sum = sum;
        case (mode_r)
            2'd1:    act_sum = sum;
            2'd2:    if (sum[AW-1]) act_sum = sum >>> LEAK_SHIFT;
            default: if (sum[AW-1]) act_sum = '0;
        endcase
    end

    // Clamp only exists when the internal sum can exceed the output range.
    generate
        if (ACC_W >= AW) begin : g_no_clamp
            assign res     = ACC_W'(act_sum);
            assign res_sat = 1'b0;
        end else begin : g_clamp
            localparam logic signed [AW-1:0] SAT_MAX =
                {{(AW - ACC_W + 1){1'b0}}, {(ACC_W - 1){1'b1}}};
            localparam logic signed [AW-1:0] SAT_MIN =
                {{(AW - ACC_W + 1){1'b1}}, {(ACC_W - 1){1'b0}}};
            always_comb begin
                res     = act_sum[ACC_W-1:0];
                res_sat = 1'b0;
                if (act_sum > SAT_MAX) begin
                    res     = SAT_MAX[ACC_W-1:0];
                    res_sat = 1'b1;
                end else if (act_sum < SAT_MIN) begin
                    res     = SAT_MIN[ACC_W-1:0];
                    res_sat = 1'b1;
                end
            end
        end
    endgenerate

    always_comb begin
        state_next = state;
        in_ready   = 1'b0;
        out_valid  = 1'b0;
        case (state)
            S_IDLE: begin
                if (start) state_next = S_ACCUM;
            end
            S_ACCUM: begin
                in_ready = 1'b1;
                if (last_beat) state_next = S_DONE;
            end
            S_DONE: begin
                out_valid = 1'b1;
                if (out_ready) state_next = S_IDLE;
            end
            default: state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state         <= S_IDLE;
            acc           <= '0;
            cnt           <= '0;
            mode_r        <= '0;
            neuron_output <= '0;
            sat           <= 1'b0;
        end else begin
            state <= state_next;
            if (state == S_IDLE && start) begin
                acc    <= AW'(bias_in);
                cnt    <= '0;
                mode_r <= act_mode;
            end else if (beat) begin
                acc <= sum;
                cnt <= cnt + 1'b1;
                if (last_beat) begin
                    neuron_output <= res;
                    sat           <= res_sat;
                end
            end
        end
    end

endmodule

// File: tb/tb_neuron_mac_seq.sv
// Directed bench for neuron_mac_seq: default instance plus an ACC_W=12
// instance sharing the same stimulus to exercise saturation.
module tb_neuron_mac_seq;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [7:0]  bias_in = '0;
    logic [1:0]  act_mode = '0;
    logic        in_valid = 1'b0;
    logic [7:0]  x_in = '0;
    logic [7:0]  w_in = '0;
    logic        out_ready = 1'b0;

    logic        in_ready, out_valid, sat;
    logic [17:0] neuron_output;
    logic [1:0]  state_dbg;
    logic        in_ready12, out_valid12, sat12;
    logic [11:0] neuron_output12;
    logic [1:0]  state_dbg12;

    int n_checks = 0;
    int n_fails  = 0;

    always #5 clk = ~clk;

    neuron_mac_seq u_dut (
        .clk(clk), .rst(rst), .start(start), .bias_in(bias_in),
        .act_mode(act_mode), .in_valid(in_valid), .in_ready(in_ready),
        .x_in(x_in), .w_in(w_in), .out_valid(out_valid), .out_ready(out_ready),
        .neuron_output(neuron_output), .sat(sat), .state_dbg(state_dbg)
    );

    neuron_mac_seq #(.ACC_W(12)) u_dut12 (
        .clk(clk), .rst(rst), .start(start), .bias_in(bias_in),
        .act_mode(act_mode), .in_valid(in_valid), .in_ready(in_ready12),
        .x_in(x_in), .w_in(w_in), .out_valid(out_valid12), .out_ready(out_ready),
        .neuron_output(neuron_output12), .sat(sat12), .state_dbg(state_dbg12)
    );

    task automatic chk18(input string tag, input logic [17:0] obs, input logic [17:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic chk12(input string tag, input logic [11:0] obs, input logic [11:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic chk1(input string tag, input logic obs, input logic exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fails++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    // Pulses start; act_mode is then scrambled to show it was latched.
    task automatic do_start(input logic [7:0] b, input logic [1:0] m);
        @(negedge clk);
        start    = 1'b1;
        bias_in  = b;
        act_mode = m;
        @(negedge clk);
        start    = 1'b0;
        act_mode = ~m;
        bias_in  = 8'h55;
    endtask

    task automatic send_beat(input logic [7:0] x, input logic [7:0] w, input int gap);
        in_valid = 1'b0;
        repeat (gap) @(negedge clk);
        in_valid = 1'b1;
        x_in     = x;
        w_in     = w;
        @(negedge clk);
        in_valid = 1'b0;
        x_in     = 8'hAA;
        w_in     = 8'hAA;
    endtask

    // Start plus four beats; returns at the negedge after the final beat.
    task automatic run4(input logic [7:0] b, input logic [1:0] m,
                        input logic [31:0] xv, input logic [31:0] wv, input int gap);
        do_start(b, m);
        for (int i = 0; i < 4; i++) send_beat(xv[8*i +: 8], wv[8*i +: 8], gap);
    endtask

    task automatic take_output();
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
    endtask

    initial begin
        // Reset values
        #1;
        chk18("rst_out", neuron_output, 18'd0);
        chk1("rst_sat", sat, 1'b0);
        chk1("rst_in_ready", in_ready, 1'b0);
        chk1("rst_out_valid", out_valid, 1'b0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk1("idle_in_ready", in_ready, 1'b0);

        // ReLU basic: 1 + 20 + 15 + 8 + 5 = 49, with latency checks
        do_start(8'd1, 2'd0);
        chk1("start_in_ready", in_ready, 1'b1);
        send_beat(8'd10, 8'd2, 0);
        send_beat(8'd5, 8'd3, 0);
        send_beat(8'd2, 8'd4, 0);
        chk1("pre_last_out_valid", out_valid, 1'b0);
        send_beat(8'd1, 8'd5, 0);
        chk1("lat_out_valid", out_valid, 1'b1);
        chk1("done_in_ready", in_ready, 1'b0);
        chk18("relu_49", neuron_output, 18'd49);
        chk1("relu_49_sat", sat, 1'b0);
        chk12("relu_49_w12", neuron_output12, 12'd49);
        take_output();
        chk1("after_hs_out_valid", out_valid, 1'b0);

        // Sum -7 in every activation mode
        run4(8'd1, 2'd0, {4{8'hFF}}, {4{8'd2}}, 0);
        chk18("neg7_relu", neuron_output, 18'd0);
        take_output();
        run4(8'd1, 2'd1, {4{8'hFF}}, {4{8'd2}}, 0);
        chk18("neg7_ident", neuron_output, 18'h3FFF9);
        take_output();
        run4(8'd1, 2'd2, {4{8'hFF}}, {4{8'd2}}, 0);
        chk18("neg7_leaky", neuron_output, 18'h3FFFF);
        take_output();
        run4(8'd1, 2'd3, {4{8'hFF}}, {4{8'd2}}, 0);
        chk18("neg7_relu3", neuron_output, 18'd0);
        take_output();

        // Sum -385
        run4(8'd127, 2'd0, {4{8'h80}}, {4{8'd1}}, 0);
        chk18("neg385_relu", neuron_output, 18'd0);
        take_output();
        run4(8'd127, 2'd2, {4{8'h80}}, {4{8'd1}}, 0);
        chk18("neg385_leaky", neuron_output, -18'sd49);
        take_output();
        run4(8'd127, 2'd1, {4{8'h80}}, {4{8'd1}}, 0);
        chk18("neg385_ident", neuron_output, -18'sd385);
        chk1("neg385_sat", sat, 1'b0);
        take_output();

        // Saturation: 64516 and -65024
        run4(8'd0, 2'd0, {4{8'd127}}, {4{8'd127}}, 0);
        chk12("satp_w12", neuron_output12, 12'd2047);
        chk1("satp_w12_sat", sat12, 1'b1);
        chk18("satp_w18", neuron_output, 18'd64516);
        chk1("satp_w18_sat", sat, 1'b0);
        take_output();
        run4(8'd0, 2'd1, {4{8'h80}}, {4{8'd127}}, 0);
        chk12("satn_w12", neuron_output12, 12'h800);
        chk1("satn_w12_sat", sat12, 1'b1);
        chk18("satn_w18", neuron_output, -18'sd65024);
        take_output();

        // Gapped beats, stalled output, start ignored in DONE: 1+10-3+10-16 = 2
        run4(8'd1, 2'd0, {8'hF0, 8'd10, 8'hFF, 8'd5}, {8'd1, 8'd1, 8'd3, 8'd2}, 2);
        for (int i = 0; i < 3; i++) begin
            chk1("stall_out_valid", out_valid, 1'b1);
            chk18("stall_out", neuron_output, 18'd2);
            start = (i == 1);
            in_valid = 1'b1;
            @(negedge clk);
            start = 1'b0;
            in_valid = 1'b0;
        end
        chk18("stall_out_end", neuron_output, 18'd2);
        chk1("stall_in_ready", in_ready, 1'b0);
        // start coinciding with the handshake is ignored
        start = 1'b1;
        take_output();
        start = 1'b0;
        chk1("hs_start_in_ready", in_ready, 1'b0);
        chk1("hs_start_out_valid", out_valid, 1'b0);
        chk18("hold_after_idle", neuron_output, 18'd2);

        // Reset mid-evaluation, then a clean evaluation
        do_start(8'd100, 2'd1);
        send_beat(8'd100, 8'd100, 0);
        send_beat(8'd100, 8'd100, 0);
        rst = 1'b1;
        #1;
        chk18("midrst_out", neuron_output, 18'd0);
        chk1("midrst_in_ready", in_ready, 1'b0);
        chk1("midrst_out_valid", out_valid, 1'b0);
        @(negedge clk);
        rst = 1'b0;
        repeat (2) @(negedge clk);
        chk1("postrst_out_valid", out_valid, 1'b0);
        run4(8'd1, 2'd0, {8'd1, 8'd2, 8'd5, 8'd10}, {8'd5, 8'd4, 8'd3, 8'd2}, 1);
        chk1("postrst_valid", out_valid, 1'b1);
        chk18("postrst_49", neuron_output, 18'd49);
        take_output();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
